// File: rtl/macro_op_sequencer.sv
// Expands CALL/RET/RTI/interrupt macro-ops into STEPS consecutive micro-opcodes for the control unit.
// Registered outputs, one cycle from accept; fetch_stall holds fetch while expanding or when downstream is not ready.
module macro_op_sequencer #(
  parameter int             OPW     = 5,
  parameter int             STEPS   = 2,
  parameter logic [OPW-1:0] CALL_OP = 5'b11000,
  parameter logic [OPW-1:0] RET_OP  = 5'b11010,
  parameter logic [OPW-1:0] RTI_OP  = 5'b11100,
  parameter logic [OPW-1:0] INT_OP  = 5'b11110
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           instr_valid,
  input  logic [OPW-1:0] instr_op,
  input  logic           intr_req,
  input  logic           flush,
  input  logic           ctrl_ready,
  output logic [OPW-1:0] op_out,
  output logic           op_valid,
  output logic           fetch_stall,
  output logic           intr_ack,
  output logic           busy
);

  localparam int            SW   = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

  typedef enum logic {PASS = 1'b0, MULTI = 1'b1} state_t;

  state_t         state, state_nx;
  logic [SW-1:0]  step, step_nx;
  logic [OPW-1:0] base, base_nx;
  logic           intr_pend, intr_pend_nx;
  logic [OPW-1:0] op_nx;
  logic           vld_nx, ack_nx, busy_nx;
  logic           accept, is_multi;

  assign fetch_stall = ~ctrl_ready | (state == MULTI) | intr_pend;
  assign accept      = instr_valid & ~fetch_stall;
  assign is_multi    = (instr_op == CALL_OP) || (instr_op == RET_OP) || (instr_op == RTI_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PASS;
      step      <= '0;
      base      <= '0;
      intr_pend <= 1'b0;
      op_out    <= '0;
      op_valid  <= 1'b0;
      intr_ack  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      step      <= step_nx;
      base      <= base_nx;
      intr_pend <= intr_pend_nx;
      op_out    <= op_nx;
      op_valid  <= vld_nx;
      intr_ack  <= ack_nx;
      busy      <= busy_nx;
    end
  end

  // Priority: flush > pending sequence step > interrupt start > accept > idle.
  always_comb begin
    state_nx     = state;
    step_nx      = step;
    base_nx      = base;
    intr_pend_nx = intr_pend;
    if (ctrl_ready) begin
      if (flush) begin
        state_nx = PASS;
        step_nx  = '0;
      end else if (state == MULTI) begin
        if (step == LAST) begin
          state_nx = PASS;
          step_nx  = '0;
        end else begin
          step_nx = step + 1'b1;
        end
      end else if (intr_pend) begin
        base_nx      = INT_OP;
        intr_pend_nx = 1'b0;
        if (STEPS > 1) begin
          state_nx = MULTI;
          step_nx  = SW'(1);
        end
      end else if (accept && is_multi) begin
        base_nx = instr_op;
        if (STEPS > 1) begin
          state_nx = MULTI;
          step_nx  = SW'(1);
        end
      end
    end
    // A request in the same cycle as the interrupt start re-arms the pending flag.
    if (intr_req) intr_pend_nx = 1'b1;
  end

  always_comb begin
    op_nx   = op_out;
    vld_nx  = op_valid;
    ack_nx  = 1'b0;
    busy_nx = (state_nx == MULTI);
    if (ctrl_ready) begin
      if (flush) begin
        op_nx  = '0;
        vld_nx = 1'b0;
      end else if (state == MULTI) begin
        op_nx  = base + OPW'(step);
        vld_nx = 1'b1;
      end else if (intr_pend) begin
        op_nx  = INT_OP;
        vld_nx = 1'b1;
        ack_nx = 1'b1;
      end else if (accept) begin
        op_nx  = instr_op;
        vld_nx = 1'b1;
      end else begin
        op_nx  = '0;
        vld_nx = 1'b0;
      end
    end
  end

endmodule

// File: doc/macro_op_sequencer.md
Name: macro_op_sequencer

Overview:
- Sits between fetch/decode and controlUnit.
- Expands multi-part macro-ops (CALL, RET, RTI, hardware interrupt) into STEPS consecutive micro-opcodes, base..base+STEPS-1, and stalls fetch while expanding.
- Latches interrupt requests and inserts the interrupt sequence only at a macro-op boundary.
- Honours a downstream hold (ctrl_ready) and a pipeline flush.

Parameters:
OPW, 5, opcode width
STEPS, 2, micro-ops per multi-part macro-op (>=1)
CALL_OP, 5'b11000, base opcode of CALL sequence
RET_OP, 5'b11010, base opcode of RET sequence
RTI_OP, 5'b11100, base opcode of RTI sequence
INT_OP, 5'b11110, base opcode of interrupt sequence

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset
instr_valid  in  1  fetch presents an instruction
instr_op  in  OPW  fetched opcode
intr_req  in  1  interrupt request, level or pulse
flush  in  1  synchronous pipeline flush
ctrl_ready  in  1  downstream can take an opcode this cycle
op_out  out  OPW  registered opcode to controlUnit
op_valid  out  1  op_out is a real instruction; 0 means NOP
fetch_stall  out  1  combinational; fetch must hold instr_op
intr_ack  out  1  registered one-cycle pulse when INT_OP issues
busy  out  1  registered; high while in MULTI state

Interface (already decided):
- One clock.
- Reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, async):
  - op_out=0, op_valid=0, intr_ack=0, busy=0.
  - state=PASS, step=0, base=0, intr_pend=0.
- States:
  - PASS: one macro-op per cycle.
  - MULTI: issuing steps 1..STEPS-1 of base.
- Step counter width is max(1, clog2(STEPS)).
- intr_pend:
  - Set on any cycle with intr_req=1.
  - Cleared only when the interrupt sequence starts; set wins over clear in the same cycle.
- fetch_stall = ~ctrl_ready | (state==MULTI) | intr_pend.
- Accept = instr_valid & ~fetch_stall.
- ctrl_ready=0: state, step, base, op_out and op_valid all hold; intr_ack goes to 0; intr_pend may still set.
- Priority each cycle with ctrl_ready=1: flush > MULTI step > interrupt start > accept > idle.
  - flush: state=PASS, step=0, op_out=0, op_valid=0. intr_pend is kept. Any remaining MULTI steps are discarded.
  - MULTI step: op_out=base+step (mod 2^OPW), op_valid=1, step++. When the issued step is STEPS-1, go to PASS and set step=0.
  - Interrupt start (PASS & intr_pend): op_out=INT_OP, op_valid=1, intr_ack=1, base=INT_OP, intr_pend=0. Go to MULTI with step=1 if STEPS>1. The waiting fetched instruction is not consumed.
  - Accept with instr_op in {CALL_OP, RET_OP, RTI_OP}: op_out=instr_op, op_valid=1, base=instr_op. Go to MULTI with step=1 if STEPS>1.
  - Accept, other opcode: op_out=instr_op, op_valid=1. This includes second-part opcodes, which pass through as single ops.
  - Idle (nothing to issue): op_out=0, op_valid=0.
- Latency: 1 cycle from accept to op_out.
- A multi-part macro-op holds fetch for exactly STEPS-1 ready cycles.
- Interrupts are never inserted mid-sequence. A request arriving during MULTI starts on the first PASS cycle after the sequence completes.
- STEPS=1: MULTI is never entered and every opcode issues singly.
- Bases must satisfy base+STEPS-1 < 2^OPW, and the base ranges must not overlap. Integration checks this; the RTL does not.
- Reset mid-MULTI aborts the sequence and returns all outputs to their reset values.

Test Plan:
- Reset with STEPS=2 -> op_out=00000, op_valid=0, busy=0. Then instr_op=00011 accepted -> next cycle op_out=00011, op_valid=1, fetch_stall stays 0.
- CALL 11000 then ADD 01001 held by fetch -> op_out sequence 11000, 11001, 01001 on consecutive cycles. fetch_stall=1 exactly one cycle; busy=1 during the 11001 issue cycle.
- intr_req pulse in the cycle RET 11010 is accepted -> op_out 11010, 11011, 11110 (intr_ack=1), 11111. The held instruction 00100 then issues after 11111.
- CALL accepted, then ctrl_ready=0 for 3 cycles -> op_out holds 11000 for 4 cycles, then 11001. No intr_ack and no extra opcodes.
- RTI 11100 accepted, flush asserted the next cycle -> op_out=00000, op_valid=0, 11101 never issued, busy=0, next fetched instruction accepted.
- rst_n low during a MULTI step of the interrupt sequence -> outputs reset immediately (async). After release, intr_pend=0 and no intr_ack.
